// File: rtl/note_voice_scheduler.sv
// Polyphonic voice allocator. Once per sample step it snapshots the note
// switches, then scans one note per cycle to assign, release or steal voices.
module note_voice_scheduler #(
  parameter int NUM_NOTES     = 8,
  parameter int NUM_VOICES    = 4,
  parameter int RELEASE_STEPS = 64
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    step_in,
  input  logic [NUM_NOTES-1:0]    notes_in,
  input  logic                    coeff_ready_in,
  output logic [NUM_VOICES*3-1:0] voice_note_out,
  output logic [NUM_VOICES-1:0]   voice_on_out,
  output logic [NUM_VOICES-1:0]   voice_gate_out,
  output logic [NUM_VOICES-1:0]   voice_start_out,
  output logic                    scan_busy_out,
  output logic                    steal_out,
  output logic                    overrun_out
);

  localparam int NOTE_W = 3;
  localparam int KW = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;
  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [7:0] REL_INIT = 8'(RELEASE_STEPS);

  typedef enum logic {IDLE, SCAN} fsm_t;
  typedef enum logic [1:0] {V_FREE, V_ACTIVE, V_RELEASE} vstate_t;

  fsm_t                  state_q, state_d;
  logic [KW-1:0]         idx_q, idx_d;
  logic [NUM_NOTES-1:0]  prev_q, prev_d, cur_q, cur_d;
  vstate_t               vst_q [NUM_VOICES];
  vstate_t               vst_d [NUM_VOICES];
  logic [7:0]            age_q [NUM_VOICES];
  logic [7:0]            age_d [NUM_VOICES];
  logic [7:0]            rel_q [NUM_VOICES];
  logic [7:0]            rel_d [NUM_VOICES];
  logic [NOTE_W-1:0]     note_q [NUM_VOICES];
  logic [NOTE_W-1:0]     note_d [NUM_VOICES];
  logic [NUM_VOICES-1:0] on_q, gate_q, start_q, start_d;
  logic                  steal_q, steal_d, overrun_q, overrun_d;

  logic                  note_on, note_off;
  logic                  have_free, have_rel, have_old;
  logic [VW-1:0]         free_idx, rel_idx, old_idx, victim;
  logic [7:0]            old_age;

  // Victim priority: lowest FREE, then lowest RELEASE, then oldest ACTIVE.
  always_comb begin
    have_free = 1'b0;
    have_rel  = 1'b0;
    have_old  = 1'b0;
    free_idx  = '0;
    rel_idx   = '0;
    old_idx   = '0;
    old_age   = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (vst_q[v] == V_FREE) begin
        have_free = 1'b1;
        free_idx  = VW'(v);
      end
      if (vst_q[v] == V_RELEASE) begin
        have_rel = 1'b1;
        rel_idx  = VW'(v);
      end
    end
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (vst_q[v] == V_ACTIVE && (!have_old || age_q[v] > old_age)) begin
        have_old = 1'b1;
        old_idx  = VW'(v);
        old_age  = age_q[v];
      end
    end
    victim = have_free ? free_idx : (have_rel ? rel_idx : old_idx);
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    prev_d    = prev_q;
    cur_d     = cur_q;
    vst_d     = vst_q;
    age_d     = age_q;
    rel_d     = rel_q;
    note_d    = note_q;
    start_d   = '0;
    steal_d   = 1'b0;
    overrun_d = 1'b0;
    note_on   = cur_q[idx_q] & ~prev_q[idx_q];
    note_off  = prev_q[idx_q] & ~cur_q[idx_q];

    case (state_q)
      IDLE: begin
        if (step_in) begin
          prev_d  = cur_q;
          cur_d   = notes_in;
          idx_d   = '0;
          state_d = SCAN;
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (vst_q[v] == V_RELEASE) begin
              if (rel_q[v] <= 8'd1) begin
                rel_d[v] = '0;
                vst_d[v] = V_FREE;
              end else begin
                rel_d[v] = rel_q[v] - 8'd1;
              end
            end else if (vst_q[v] == V_ACTIVE && age_q[v] != 8'hFF) begin
              age_d[v] = age_q[v] + 8'd1;
            end
          end
        end
      end
      SCAN: begin
        overrun_d = step_in;
        if (note_off) begin
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (vst_q[v] == V_ACTIVE && note_q[v] == NOTE_W'(idx_q)) begin
              vst_d[v] = V_RELEASE;
              rel_d[v] = REL_INIT;
            end
          end
        end
        if (note_on && coeff_ready_in) begin
          vst_d[victim]   = V_ACTIVE;
          note_d[victim]  = NOTE_W'(idx_q);
          age_d[victim]   = '0;
          rel_d[victim]   = '0;
          start_d[victim] = 1'b1;
          steal_d         = (vst_q[victim] == V_ACTIVE);
        end
        if (idx_q == KW'(NUM_NOTES - 1)) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + KW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      prev_q    <= '0;
      cur_q     <= '0;
      on_q      <= '0;
      gate_q    <= '0;
      start_q   <= '0;
      steal_q   <= 1'b0;
      overrun_q <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        vst_q[v]  <= V_FREE;
        age_q[v]  <= '0;
        rel_q[v]  <= '0;
        note_q[v] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      prev_q    <= prev_d;
      cur_q     <= cur_d;
      start_q   <= start_d;
      steal_q   <= steal_d;
      overrun_q <= overrun_d;
      for (int v = 0; v < NUM_VOICES; v++) begin
        vst_q[v]  <= vst_d[v];
        age_q[v]  <= age_d[v];
        rel_q[v]  <= rel_d[v];
        note_q[v] <= note_d[v];
        on_q[v]   <= (vst_d[v] != V_FREE);
        gate_q[v] <= (vst_d[v] == V_ACTIVE);
      end
    end
  end

  always_comb begin
    voice_note_out = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_note_out[v*NOTE_W +: NOTE_W] = note_q[v];
    end
  end

  assign voice_on_out    = on_q;
  assign voice_gate_out  = gate_q;
  assign voice_start_out = start_q;
  assign scan_busy_out   = (state_q == SCAN);
  assign steal_out       = steal_q;
  assign overrun_out     = overrun_q;

endmodule

// File: tb/tb_note_voice_scheduler.sv
// Bench for note_voice_scheduler: directed scenarios plus random steps,
// all checked against a whole-scan behavioural model of the allocator.
module tb_note_voice_scheduler;

  localparam int NN = 8;
  localparam int NV = 4;
  localparam int RS = 3;
  localparam int M_FREE = 0;
  localparam int M_ACT  = 1;
  localparam int M_REL  = 2;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic            step_in;
  logic [NN-1:0]   notes_in;
  logic            coeff_ready_in;
  logic [NV*3-1:0] voice_note_out;
  logic [NV-1:0]   voice_on_out, voice_gate_out, voice_start_out;
  logic            scan_busy_out, steal_out, overrun_out;

  int assertCount = 0;
  int failCount   = 0;

  int            mState [NV];
  int            mAge   [NV];
  int            mRel   [NV];
  int            mNote  [NV];
  logic [NN-1:0] mPrev, mCur;
  logic [NV-1:0] expStart [NN];
  logic [NN-1:0] expSteal;

  note_voice_scheduler #(
    .NUM_NOTES(NN), .NUM_VOICES(NV), .RELEASE_STEPS(RS)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .step_in(step_in), .notes_in(notes_in),
    .coeff_ready_in(coeff_ready_in), .voice_note_out(voice_note_out),
    .voice_on_out(voice_on_out), .voice_gate_out(voice_gate_out),
    .voice_start_out(voice_start_out), .scan_busy_out(scan_busy_out),
    .steal_out(steal_out), .overrun_out(overrun_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [NV-1:0] model_mask(input int st);
    logic [NV-1:0] m;
    m = '0;
    for (int v = 0; v < NV; v++) m[v] = (mState[v] == st);
    return m;
  endfunction

  function automatic logic [NV*3-1:0] model_notes();
    logic [NV*3-1:0] n;
    n = '0;
    for (int v = 0; v < NV; v++) n[v*3 +: 3] = 3'(mNote[v]);
    return n;
  endfunction

  task automatic model_reset();
    mPrev = '0;
    mCur  = '0;
    for (int v = 0; v < NV; v++) begin
      mState[v] = M_FREE;
      mAge[v]   = 0;
      mRel[v]   = 0;
      mNote[v]  = 0;
    end
  endtask

  // Snapshot plus the per-step ageing and release countdown.
  task automatic model_step_phase();
    mPrev = mCur;
    mCur  = notes_in;
    for (int v = 0; v < NV; v++) begin
      if (mState[v] == M_REL) begin
        mRel[v] = mRel[v] - 1;
        if (mRel[v] <= 0) begin
          mRel[v]   = 0;
          mState[v] = M_FREE;
        end
      end else if (mState[v] == M_ACT) begin
        mAge[v] = (mAge[v] >= 255) ? 255 : mAge[v] + 1;
      end
    end
  endtask

  // Walks the notes in order, recording which voice each note-on lands on.
  task automatic model_scan(input logic coeff);
    int victim, best;
    for (int k = 0; k < NN; k++) begin
      expStart[k] = '0;
      expSteal[k] = 1'b0;
      if (mPrev[k] && !mCur[k]) begin
        for (int v = 0; v < NV; v++) begin
          if (mState[v] == M_ACT && mNote[v] == k) begin
            mState[v] = M_REL;
            mRel[v]   = RS;
          end
        end
      end
      if (!mPrev[k] && mCur[k] && coeff) begin
        victim = -1;
        best   = -1;
        for (int v = 0; v < NV; v++) if (victim < 0 && mState[v] == M_FREE) victim = v;
        for (int v = 0; v < NV; v++) if (victim < 0 && mState[v] == M_REL) victim = v;
        if (victim < 0) begin
          for (int v = 0; v < NV; v++) begin
            if (mState[v] == M_ACT && mAge[v] > best) begin
              best   = mAge[v];
              victim = v;
            end
          end
          expSteal[k] = 1'b1;
        end
        expStart[k][victim] = 1'b1;
        mState[victim] = M_ACT;
        mNote[victim]  = k;
        mAge[victim]   = 0;
        mRel[victim]   = 0;
      end
    end
  endtask

  // Issues one step and checks every cycle of the resulting scan.
  // extraAt > 0 fires a second step_in in cycle t+extraAt.
  task automatic do_step(input int extraAt);
    logic [NV-1:0] expOn, expStartNow;
    logic          expBusy, expStealNow, expOv;
    step_in = 1'b1;
    model_step_phase();
    expOn = ~model_mask(M_FREE);
    model_scan(coeff_ready_in);
    tick();
    step_in = 1'b0;
    for (int c = 1; c <= NN + 1; c++) begin
      if (c == 1) begin
        assertCount++;
        if (voice_on_out !== expOn) begin
          failCount++;
          $display("[TB] FAIL on_after_step: got %b expected %b", voice_on_out, expOn);
        end
      end
      expBusy     = (c <= NN);
      expStartNow = (c >= 2) ? expStart[c-2] : '0;
      expStealNow = (c >= 2) ? expSteal[c-2] : 1'b0;
      expOv       = (extraAt > 0) && (c == extraAt + 1);
      assertCount++;
      if (scan_busy_out !== expBusy) begin
        failCount++;
        $display("[TB] FAIL scan_busy c=%0d: got %b expected %b", c, scan_busy_out, expBusy);
      end
      assertCount++;
      if (voice_start_out !== expStartNow) begin
        failCount++;
        $display("[TB] FAIL voice_start c=%0d: got %b expected %b", c, voice_start_out, expStartNow);
      end
      assertCount++;
      if (steal_out !== expStealNow) begin
        failCount++;
        $display("[TB] FAIL steal c=%0d: got %b expected %b", c, steal_out, expStealNow);
      end
      assertCount++;
      if (overrun_out !== expOv) begin
        failCount++;
        $display("[TB] FAIL overrun c=%0d: got %b expected %b", c, overrun_out, expOv);
      end
      if (c <= NN) begin
        step_in = (c == extraAt);
        tick();
        step_in = 1'b0;
      end
    end
    assertCount++;
    if (voice_on_out !== ~model_mask(M_FREE)) begin
      failCount++;
      $display("[TB] FAIL voice_on: got %b expected %b", voice_on_out, ~model_mask(M_FREE));
    end
    assertCount++;
    if (voice_gate_out !== model_mask(M_ACT)) begin
      failCount++;
      $display("[TB] FAIL voice_gate: got %b expected %b", voice_gate_out, model_mask(M_ACT));
    end
    assertCount++;
    if (voice_note_out !== model_notes()) begin
      failCount++;
      $display("[TB] FAIL voice_note: got %h expected %h", voice_note_out, model_notes());
    end
  endtask

  task automatic apply_reset();
    rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    assertCount++;
    if ({voice_on_out, voice_gate_out, voice_start_out} !== '0) begin
      failCount++;
      $display("[TB] FAIL %s voice flags: got %b %b %b expected 0", tag,
               voice_on_out, voice_gate_out, voice_start_out);
    end
    assertCount++;
    if (voice_note_out !== '0) begin
      failCount++;
      $display("[TB] FAIL %s voice_note: got %h expected 0", tag, voice_note_out);
    end
    assertCount++;
    if ({scan_busy_out, steal_out, overrun_out} !== 3'b000) begin
      failCount++;
      $display("[TB] FAIL %s busy/steal/overrun: got %b%b%b expected 000", tag,
               scan_busy_out, steal_out, overrun_out);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    tick();
    tick();
    model_reset();
    check_all_zero("reset");
    rst_in = 1'b1;
    tick();
  endtask

  task automatic test_single_note();
    apply_reset();
    coeff_ready_in = 1'b1;
    notes_in = 8'h01;
    do_step(0);
    assertCount++;
    if (voice_gate_out !== 4'b0001 || voice_note_out[2:0] !== 3'd0) begin
      failCount++;
      $display("[TB] FAIL single_note: got gate %b note %0d expected 0001 0",
               voice_gate_out, voice_note_out[2:0]);
    end
  endtask

  task automatic test_steal();
    idle(2);
    notes_in = 8'h0F;
    do_step(0);
    idle(2);
    notes_in = 8'h1F;
    do_step(0);
    assertCount++;
    if (voice_note_out[2:0] !== 3'd4 || voice_gate_out !== 4'b1111) begin
      failCount++;
      $display("[TB] FAIL steal_note: got note0 %0d gate %b expected 4 1111",
               voice_note_out[2:0], voice_gate_out);
    end
  endtask

  task automatic test_release();
    apply_reset();
    notes_in = 8'h01;
    do_step(0);
    idle(1);
    notes_in = 8'h00;
    do_step(0);
    assertCount++;
    if (voice_gate_out[0] !== 1'b0 || voice_on_out[0] !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL release_start: got gate %b on %b expected 0 1",
               voice_gate_out[0], voice_on_out[0]);
    end
    for (int s = 1; s <= RS; s++) begin
      idle(1);
      do_step(0);
      assertCount++;
      if (voice_on_out[0] !== (s < RS)) begin
        failCount++;
        $display("[TB] FAIL release_step%0d: got on %b expected %b", s, voice_on_out[0], s < RS);
      end
    end
  endtask

  task automatic test_coeff_gate();
    apply_reset();
    coeff_ready_in = 1'b0;
    notes_in = 8'h04;
    do_step(0);
    coeff_ready_in = 1'b1;
    idle(1);
    do_step(0);
    assertCount++;
    if (voice_on_out !== 4'b0000) begin
      failCount++;
      $display("[TB] FAIL coeff_held_silent: got on %b expected 0000", voice_on_out);
    end
    notes_in = 8'h00;
    do_step(0);
    notes_in = 8'h04;
    do_step(0);
    assertCount++;
    if (voice_gate_out !== 4'b0001 || voice_note_out[2:0] !== 3'd2) begin
      failCount++;
      $display("[TB] FAIL coeff_repress: got gate %b note %0d expected 0001 2",
               voice_gate_out, voice_note_out[2:0]);
    end
  endtask

  task automatic test_overrun();
    notes_in = 8'h24;
    idle(1);
    do_step(4);
  endtask

  task automatic test_reset_mid_scan();
    apply_reset();
    notes_in = 8'h03;
    step_in = 1'b1;
    tick();
    step_in = 1'b0;
    tick();
    tick();
    rst_in = 1'b0;
    tick();
    model_reset();
    check_all_zero("mid_scan_reset");
    rst_in = 1'b1;
    tick();
    do_step(0);
    assertCount++;
    if (voice_gate_out !== 4'b0011 || voice_note_out[5:0] !== 6'b001_000) begin
      failCount++;
      $display("[TB] FAIL after_abort: got gate %b notes %h expected 0011 08",
               voice_gate_out, voice_note_out[5:0]);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) != 0) notes_in = NN'($urandom);
      coeff_ready_in = ($urandom_range(0, 4) != 0);
      do_step(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, NN)) : 0);
      idle(int'($urandom_range(0, 3)));
    end
    coeff_ready_in = 1'b1;
  endtask

  initial begin
    rst_in         = 1'b0;
    step_in        = 1'b0;
    notes_in       = '0;
    coeff_ready_in = 1'b1;
    model_reset();
    test_reset();
    test_single_note();
    test_steal();
    test_release();
    test_coeff_gate();
    test_overrun();
    test_reset_mid_scan();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
